// File: rtl/fd_queue_pkg.sv
// Shared types and constants for the fetch/decode instruction queue.
package fd_pkg;
  parameter int XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcplus4;
  } fd_entry_t;

  localparam int ARM_PC_OFFSET = 8;
  localparam int RV_PC_OFFSET  = 4;
endpackage

// File: rtl/fd_queue_if.sv
// Fetch-side and decode-side handshake bundle of the instruction queue.
interface fd_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH+1)
);
  logic            arm;
  logic            validF;
  logic [XLEN-1:0] RDF;
  logic [XLEN-1:0] PCF;
  logic [XLEN-1:0] PCPlus4F;
  logic            readyF;
  logic [XLEN-1:0] instrD;
  logic [XLEN-1:0] PCD;
  logic [XLEN-1:0] PCPlus4D;
  logic [XLEN-1:0] r15D;
  logic            validD;
  logic            stallD;
  logic            flushD;
  logic [CW-1:0]   countD;

  // master: the pipeline around the queue; slave: the queue itself
  modport master (
    output arm, validF, RDF, PCF, PCPlus4F, stallD, flushD,
    input  readyF, instrD, PCD, PCPlus4D, r15D, validD, countD
  );
  modport slave (
    input  arm, validF, RDF, PCF, PCPlus4F, stallD, flushD,
    output readyF, instrD, PCD, PCPlus4D, r15D, validD, countD
  );
endinterface

// File: rtl/fd_queue_mem.sv
// Entry storage: one write port, one asynchronous read port, no reset.
module fd_queue_mem
  import fd_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  fd_entry_t     wdata,
  input  logic [AW-1:0] raddr,
  output fd_entry_t     rdata
);
  fd_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/fd_queue.sv
// Fetch-to-decode instruction FIFO with show-ahead head, one-cycle flush
// and ISA-dependent r15 read value.
module fd_queue
  import fd_pkg::*;
#(
  parameter int XLEN  = fd_pkg::XLEN,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input logic       clk,
  input logic       rst,
  fd_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] count_q, count_d;
  logic          ready, valid, enq, deq, we;
  fd_entry_t     wdata, head;

  // Handshakes see only registered state and rst, never validF/stallD.
  assign ready = rst & (count_q < CW'(DEPTH));
  assign valid = rst & (count_q != '0);
  assign enq   = q.validF & ready;
  assign deq   = valid & ~q.stallD;
  assign we    = enq & ~q.flushD;
  assign wdata = '{instr: q.RDF, pc: q.PCF, pcplus4: q.PCPlus4F};

  always_comb begin
    wp_d    = wp_q + AW'(enq);
    rp_d    = rp_q + AW'(deq);
    count_d = count_q + CW'(enq) - CW'(deq);
    if (q.flushD) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  fd_queue_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (wp_q),
    .wdata (wdata),
    .raddr (rp_q),
    .rdata (head)
  );

  // Empty head reads as an all-zero bubble on every data output.
  always_comb begin
    q.readyF   = ready;
    q.validD   = valid;
    q.countD   = rst ? count_q : '0;
    q.instrD   = '0;
    q.PCD      = '0;
    q.PCPlus4D = '0;
    q.r15D     = '0;
    if (valid) begin
      q.instrD   = head.instr;
      q.PCD      = head.pc;
      q.PCPlus4D = head.pcplus4;
      q.r15D     = head.pc + XLEN'(q.arm ? ARM_PC_OFFSET : RV_PC_OFFSET);
    end
  end
endmodule
